// File: rtl/hue_fader_pkg.sv
// Shared helpers for the hue fader: width calculations and the phase-to-channel
// ramp decode used by the sequencer.
package hue_pkg;

  localparam int DEF_NUM_CH       = 3;
  localparam int DEF_PWM_INTERVAL = 1200;
  localparam int DEF_RAMP_DIV     = 1667;

  function automatic int calc_dw(input int pwm_interval);
    return $clog2(pwm_interval + 1);
  endfunction

  function automatic int calc_pw(input int num_ch);
    return $clog2(2 * num_ch);
  endfunction

  function automatic int calc_divw(input int ramp_div);
    return (ramp_div > 1) ? $clog2(ramp_div) : 1;
  endfunction

  function automatic int calc_chw(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Even phase 2k ramps channel (k+1) mod N up; odd phase 2k+1 ramps channel k down.
  function automatic int ramp_ch(input int p, input int num_ch);
    int k;
    k = p / 2;
    if ((p % 2) == 0)
      return (k + 1 == num_ch) ? 0 : k + 1;
    else
      return k;
  endfunction

  function automatic logic ramp_up(input int p);
    return ((p % 2) == 0);
  endfunction

endpackage

// File: rtl/hue_fader_if.sv
// Control and observation bundle of the hue fader; the slave side is the fader.
interface hue_fader_if
  import hue_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int PWM_INTERVAL = DEF_PWM_INTERVAL
);
  localparam int DW = calc_dw(PWM_INTERVAL);
  localparam int PW = calc_pw(NUM_CH);

  logic                 en;
  logic                 dir;
  logic [NUM_CH-1:0]    led;
  logic [PW-1:0]        phase;
  logic [NUM_CH*DW-1:0] duty;

  modport master (output en, dir, input led, phase, duty);
  modport slave  (input en, dir, output led, phase, duty);
endinterface

// File: rtl/hue_fader_pwm_shadow.sv
// One PWM channel: the duty is captured into a shadow register at the period
// boundary so a change never lands mid-period; the output bit is registered.
module pwm_shadow #(
  parameter int DW         = 11,
  parameter int RST_DUTY   = 0,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_pcnt,
  input  logic          i_wrap,
  input  logic [DW-1:0] i_duty,
  output logic          o_led
);
  logic [DW-1:0] r_act;
  logic          r_led;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act <= DW'(RST_DUTY);
      r_led <= ACTIVE_LOW;
    end else begin
      if (i_wrap)
        r_act <= i_duty;
      r_led <= (i_pcnt < r_act) ^ ACTIVE_LOW;
    end
  end

  assign o_led = r_led;
endmodule

// File: rtl/hue_fader.sv
// Colour-wheel fader: a step sequencer walks 2*NUM_CH ramp phases (forward or
// exactly reversed) and feeds per-channel period-aligned PWM generators.
module hue_fader
  import hue_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int PWM_INTERVAL = DEF_PWM_INTERVAL,
  parameter int RAMP_DIV     = DEF_RAMP_DIV,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  hue_fader_if.slave  bus
);
  localparam int DW   = calc_dw(PWM_INTERVAL);
  localparam int PW   = calc_pw(NUM_CH);
  localparam int DIVW = calc_divw(RAMP_DIV);
  localparam int CHW  = calc_chw(NUM_CH);

  localparam logic [DW-1:0]   TICK_MAX = DW'(PWM_INTERVAL - 1);
  localparam logic [DW-1:0]   DUTY_MAX = DW'(PWM_INTERVAL);
  localparam logic [DIVW-1:0] DIV_MAX  = DIVW'(RAMP_DIV - 1);
  localparam logic [PW-1:0]   PH_MAX   = PW'(2 * NUM_CH - 1);

  logic [DIVW-1:0]      r_div;
  logic [DW-1:0]        r_tick;
  logic [PW-1:0]        r_phase;
  logic [DW-1:0]        r_pcnt;

  logic                 w_strobe;
  logic                 w_wrap;
  logic                 w_back;
  logic [PW-1:0]        w_prev_phase;
  logic [PW-1:0]        w_step_phase;
  logic [CHW-1:0]       w_step_ch;
  logic                 w_step_up;
  logic [NUM_CH*DW-1:0] w_duty;
  logic [NUM_CH-1:0]    w_led;

  assign w_strobe     = bus.en && (r_div == DIV_MAX);
  assign w_wrap       = (r_pcnt == TICK_MAX);
  assign w_prev_phase = (r_phase == '0) ? PH_MAX : r_phase - PW'(1);
  // Reversing out of tick 0 undoes the last step of the previous phase.
  assign w_back       = bus.dir && (r_tick == '0);
  assign w_step_phase = w_back ? w_prev_phase : r_phase;

  always_comb begin
    w_step_ch = CHW'(ramp_ch(int'(w_step_phase), NUM_CH));
    w_step_up = ramp_up(int'(w_step_phase)) ^ bus.dir;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_tick  <= '0;
      r_phase <= '0;
    end else if (bus.en) begin
      if (w_strobe) begin
        r_div <= '0;
        if (!bus.dir) begin
          if (r_tick == TICK_MAX) begin
            r_tick  <= '0;
            r_phase <= (r_phase == PH_MAX) ? '0 : r_phase + PW'(1);
          end else begin
            r_tick <= r_tick + DW'(1);
          end
        end else if (w_back) begin
          r_tick  <= TICK_MAX;
          r_phase <= w_prev_phase;
        end else begin
          r_tick <= r_tick - DW'(1);
        end
      end else begin
        r_div <= r_div + DIVW'(1);
      end
    end
  end

  // The PWM counter free-runs regardless of en so the LEDs keep refreshing.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_pcnt <= '0;
    else
      r_pcnt <= w_wrap ? '0 : r_pcnt + DW'(1);
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DW-1:0] r_duty;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_duty <= (gi == 0) ? DUTY_MAX : '0;
        end else if (w_strobe && (w_step_ch == CHW'(gi))) begin
          if (w_step_up) begin
            if (r_duty != DUTY_MAX)
              r_duty <= r_duty + DW'(1);
          end else if (r_duty != '0) begin
            r_duty <= r_duty - DW'(1);
          end
        end
      end

      assign w_duty[gi*DW +: DW] = r_duty;

      pwm_shadow #(
        .DW         (DW),
        .RST_DUTY   ((gi == 0) ? PWM_INTERVAL : 0),
        .ACTIVE_LOW (ACTIVE_LOW)
      ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pcnt (r_pcnt),
        .i_wrap (w_wrap),
        .i_duty (r_duty),
        .o_led  (w_led[gi])
      );
    end
  endgenerate

  assign bus.duty  = w_duty;
  assign bus.led   = w_led;
  assign bus.phase = r_phase;
endmodule

// File: doc/hue_fader.md
# hue_fader

Parametrised N-channel colour-wheel fader for the board LEDs. It steps through 2·NUM_CH phases. In each phase exactly one channel ramps its PWM duty linearly between 0 and 100% while every other channel holds its duty. It adds four things to the fixed 3-channel design: run/pause, direction reversal (exact undo of forward motion), glitch-free period-aligned duty updates and selectable output polarity. It sits at the top level, with `led[]` driving the RGB pads directly.

## Interface
Parameters:
- NUM_CH, 3: channel count, ≥2.
- PWM_INTERVAL, 1200: PWM period in clk cycles (100 µs at 12 MHz), ≥2. It is also the number of duty steps per phase.
- RAMP_DIV, 1667: clk cycles per duty step, ≥1. Phase length is PWM_INTERVAL·RAMP_DIV = 2,000,400 cycles.
- ACTIVE_LOW, 1: 1 means `led` is inverted (0 = lit).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- en  in  1  1 = sequencer advances; 0 = freeze sequencer (PWM keeps running).
- dir  in  1  0 = forward, 1 = reverse.
- led  out  NUM_CH  registered PWM outputs, polarity per ACTIVE_LOW.
- phase  out  $clog2(2·NUM_CH)  current phase.
- duty  out  NUM_CH·DW  flattened live duty registers, ch0 in LSBs. DW = $clog2(PWM_INTERVAL+1).

## Operation
- Phase decode for phase p:
  - Even p = 2k: channel (k+1) mod NUM_CH ramps up.
  - Odd p = 2k+1: channel k ramps down.
  - For NUM_CH=3 this gives the sequence G↑ R↓ B↑ G↓ R↑ B↓.
- Step strobe: divider counts 0..RAMP_DIV-1 only while en=1. The strobe fires when the divider reaches RAMP_DIV-1 with en=1.
- `tick` counts 0..PWM_INTERVAL-1 within a phase.
- Forward step from (p, t):
  - Apply phase p's ramp (±1) to its channel.
  - If t = PWM_INTERVAL-1, go to (p+1 mod 2N, 0); otherwise go to (p, t+1).
- Reverse step from (p, t), which undoes the forward step that led here:
  - If t > 0: go to (p, t-1) and apply the inverse of phase p's ramp.
  - If t = 0: go to (p-1 mod 2N, PWM_INTERVAL-1) and apply the inverse of phase p-1's ramp.
- Duty stays within [0, PWM_INTERVAL] by construction. Implementation also saturates it at both ends.
- `dir` is sampled on the strobe cycle only. It may toggle at any time, including mid-phase.
- PWM:
  - One shared counter `pcnt` runs 0..PWM_INTERVAL-1 continuously and ignores en.
  - Per-channel shadow register `act` loads `duty` when pcnt = PWM_INTERVAL-1.
  - Raw output = (pcnt < act). duty = PWM_INTERVAL means always on; duty = 0 means always off.
  - A duty change never takes effect mid-period.
- `led` = raw XOR ACTIVE_LOW, registered.

## Timing
- Reset values, visible the cycle after rst_n=0 is sampled:
  - phase=0, tick=0, divider=0, pcnt=0.
  - duty: ch0 = PWM_INTERVAL, all others 0; act holds the same values.
  - led = inactive level for all channels (all 1 when ACTIVE_LOW).
- After reset release, ch0 is lit from the second cycle on, because led is registered one cycle behind pcnt/act.
- Step latency: the duty, tick and phase updates are visible the cycle after the strobe cycle.
- Duty-to-LED latency: the change reaches led at the next period boundary plus 1 cycle.
- en=0 during a would-be strobe cycle: no step; divider holds its value.
- Simultaneous strobe and pcnt = PWM_INTERVAL-1: act loads the pre-step duty. The new duty waits one full period.
- Reset mid-operation overrides everything in the same cycle, including en, dir and a pending strobe.

## Structure
- Package `hue_pkg` holds:
  - function `ramp_ch(p, NUM_CH)` and function `ramp_up(p)`;
  - localparams for the width calculations (DW, phase width; divider width is max(1, $clog2(RAMP_DIV))).
- Sub-module `pwm_shadow`: one per channel. It takes the shared pcnt, the wrap flag and duty, and produces the registered, polarity-adjusted led bit.
- Sequencer (divider, tick, phase, duty array) lives in `hue_fader`.

## Test plan
All scenarios use NUM_CH=3, PWM_INTERVAL=4, RAMP_DIV=2, ACTIVE_LOW=1.
- Reset:
  - Hold rst_n=0 for 3 cycles, then release with en=0.
  - Required: duty={0,0,4} (ch2..ch0), phase=0, led[0]=0 constant from the second cycle, led[2:1]=2'b11 constant.
- Forward cycle:
  - en=1, dir=0.
  - Required: after 8 cycles phase=1 with duty ch1=4; after 48 cycles phase=0 with duty={0,0,4} again. Each strobe moves exactly one channel by exactly 1.
- Reverse from reset:
  - en=1, dir=1.
  - Required: first strobe gives phase=5, tick=3, ch2 duty=1; after 8 cycles phase=5, tick=0, ch2 duty=4.
- Reversibility:
  - Run forward 5 steps (into phase 1), then dir=1 for 5 steps.
  - Required: state equals the reset state exactly.
- Freeze and period alignment:
  - Drop en for 20 cycles mid-ramp.
  - Required: duty, phase and tick unchanged, and led keeps toggling per act.
  - At duty=2, led[ch] is low exactly 2 of every 4 cycles.
  - A duty change mid-period is not visible until the next period.
- Reset mid-operation:
  - Drive rst_n=0 for 1 cycle in phase 3 with en=1 and a strobe due.
  - Required: full reset values the next cycle; no step is applied.
